bird_physics: RTL and testbench

BIRD_PHYSICS -- requirements
Module: bird_physics

---
 rtl/bird_pkg.sv | 20 ++
 rtl/sync_edge.sv | 34 +++
 rtl/bird_physics.sv | 156 +++++++++++++++
 tb/tb_bird_physics.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared bird constants: state encoding and default physics values,
// also used by the pixel generator for sprite placement.
package bird_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2
   } bird_state_e;

   localparam int SCREEN_H        = 480;
   localparam int BIRD_H          = 50;
   localparam int Y_MAX_DEF       = SCREEN_H - BIRD_H;
   localparam int Y_START_DEF     = 215;
   localparam int GRAVITY_DEF     = 1;
   localparam int FLAP_VEL_DEF    = -8;
   localparam int VMAX_DEF        = 8;
   localparam int DEAD_FRAMES_DEF = 60;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector producing a single-cycle pulse.
module sync_edge (
   input  logic dclk,
   input  logic clr,
   input  logic din,
   output logic pulse
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/bird_physics.sv
// Bird motion and game-state FSM; all visible state advances once per
// frame, on the vsync falling edge, so it is stable during active video.
module bird_physics
   import bird_pkg::*;
#(
   parameter int GRAVITY     = GRAVITY_DEF,
   parameter int FLAP_VEL    = FLAP_VEL_DEF,
   parameter int VMAX        = VMAX_DEF,
   parameter int Y_START     = Y_START_DEF,
   parameter int Y_MAX       = Y_MAX_DEF,
   parameter int DEAD_FRAMES = DEAD_FRAMES_DEF
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       vsync,
   input  logic       flap,
   input  logic       collide,
   output logic [9:0] bird_y,
   output logic [7:0] bird_vel,
   output logic [1:0] state,
   output logic       alive
);

   localparam logic signed [8:0]  GRAV_S  = 9'(GRAVITY);
   localparam logic signed [8:0]  VMAX_S  = 9'(VMAX);
   localparam logic signed [7:0]  FLAP_S  = 8'(FLAP_VEL);
   localparam logic signed [10:0] YMAX_S  = 11'(Y_MAX);
   localparam logic [9:0]         YSTART  = 10'(Y_START);
   localparam logic [9:0]         YMAX_U  = 10'(Y_MAX);
   localparam logic [7:0]         DEAD_N  = 8'(DEAD_FRAMES);

   logic flap_pulse;

   sync_edge u_flap_sync (
      .dclk  (dclk),
      .clr   (clr),
      .din   (flap),
      .pulse (flap_pulse)
   );

   logic vs_q, vs_d, vs_prev_q, vs_prev_d;
   logic pend_q, pend_d;
   logic frame_tick, flap_now;
   bird_state_e st_q, st_d;
   logic [9:0] y_q, y_d;
   logic signed [7:0] v_q, v_d;
   logic [7:0] cnt_q, cnt_d;

   logic signed [8:0]  v_grav;
   logic signed [7:0]  v_new;
   logic signed [10:0] y_new;
   logic [9:0]         mv_y;
   logic signed [7:0]  mv_v;
   logic               mv_dead;

   assign frame_tick = vs_prev_q & ~vs_q;
   assign flap_now   = pend_q | flap_pulse;

   // Candidate motion for this tick; IDLE always launches with a flap
   always_comb begin
      v_grav = {v_q[7], v_q} + GRAV_S;
      if (flap_now || st_q == ST_IDLE) begin
         v_new = FLAP_S;
      end else if (v_grav > VMAX_S) begin
         v_new = VMAX_S[7:0];
      end else begin
         v_new = v_grav[7:0];
      end
      y_new   = $signed({1'b0, y_q}) + 11'(v_new);
      mv_y    = y_new[9:0];
      mv_v    = v_new;
      mv_dead = 1'b0;
      if (y_new < 0) begin
         mv_y = '0;
         mv_v = '0;
      end else if (y_new >= YMAX_S) begin
         mv_y    = YMAX_U;
         mv_v    = '0;
         mv_dead = 1'b1;
      end
   end

   always_comb begin
      vs_d      = vsync;
      vs_prev_d = vs_q;
      pend_d    = (pend_q | flap_pulse) & ~frame_tick;
      st_d      = st_q;
      y_d       = y_q;
      v_d       = v_q;
      cnt_d     = cnt_q;
      if (frame_tick) begin
         unique case (st_q)
            ST_IDLE: begin
               if (flap_now) begin
                  st_d  = mv_dead ? ST_DEAD : ST_PLAY;
                  y_d   = mv_y;
                  v_d   = mv_v;
                  cnt_d = '0;
               end
            end
            ST_PLAY: begin
               if (collide) begin
                  st_d  = ST_DEAD;
                  cnt_d = '0;
               end else begin
                  st_d  = mv_dead ? ST_DEAD : ST_PLAY;
                  y_d   = mv_y;
                  v_d   = mv_v;
                  cnt_d = '0;
               end
            end
            ST_DEAD: begin
               if (cnt_q >= DEAD_N && flap_now) begin
                  st_d  = ST_IDLE;
                  y_d   = YSTART;
                  v_d   = '0;
                  cnt_d = '0;
               end else if (cnt_q != 8'hFF) begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               st_d = ST_IDLE;
               y_d  = YSTART;
               v_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         vs_q      <= 1'b1;
         vs_prev_q <= 1'b1;
         pend_q    <= 1'b0;
         st_q      <= ST_IDLE;
         y_q       <= YSTART;
         v_q       <= '0;
         cnt_q     <= '0;
      end else begin
         vs_q      <= vs_d;
         vs_prev_q <= vs_prev_d;
         pend_q    <= pend_d;
         st_q      <= st_d;
         y_q       <= y_d;
         v_q       <= v_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bird_y   = y_q;
   assign bird_vel = v_q;
   assign state    = st_q;
   assign alive    = (st_q == ST_PLAY);

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: a default instance plus one with a
// zero flap velocity for the free-fall sequence.
module tb_bird_physics;

   logic dclk = 1'b0;
   logic clr = 1'b1;
   logic vsync = 1'b1;
   logic flap = 1'b0;
   logic collide = 1'b0;

   logic [9:0] y1, y2;
   logic [7:0] v1, v2;
   logic [1:0] s1, s2;
   logic a1, a2;

   int total = 0;
   int bad = 0;

   always #20 dclk = ~dclk;

   bird_physics dut1 (
      .dclk     (dclk),
      .clr      (clr),
      .vsync    (vsync),
      .flap     (flap),
      .collide  (collide),
      .bird_y   (y1),
      .bird_vel (v1),
      .state    (s1),
      .alive    (a1)
   );

   bird_physics #(.FLAP_VEL(0)) dut2 (
      .dclk     (dclk),
      .clr      (clr),
      .vsync    (vsync),
      .flap     (flap),
      .collide  (collide),
      .bird_y   (y2),
      .bird_vel (v2),
      .state    (s2),
      .alive    (a2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic logic [31:0] sx8(input logic [7:0] v);
      return {{24{v[7]}}, v};
   endfunction

   task automatic chk1(input string tag, input int ey, input int ev,
                       input int es);
      chk({tag, ".y1"}, {22'd0, y1}, ey);
      chk({tag, ".v1"}, sx8(v1), ev);
      chk({tag, ".s1"}, {30'd0, s1}, es);
      chk({tag, ".a1"}, {31'd0, a1}, {31'd0, es == 1});
   endtask

   task automatic chk2(input string tag, input int ey, input int ev,
                       input int es);
      chk({tag, ".y2"}, {22'd0, y2}, ey);
      chk({tag, ".v2"}, sx8(v2), ev);
      chk({tag, ".s2"}, {30'd0, s2}, es);
      chk({tag, ".a2"}, {31'd0, a2}, {31'd0, es == 1});
   endtask

   // One frame: optional flap press early, vsync falls, one update
   task automatic frame(input bit fl, input bit co, input bit stab);
      logic [9:0] y0;
      logic [7:0] v0;
      logic [1:0] st0;
      y0 = y1;
      v0 = v1;
      st0 = s1;
      flap = fl;
      collide = co;
      for (int i = 0; i < 6; i++) begin
         @(negedge dclk);
         if (i == 2) flap = 1'b0;
         if (stab) begin
            chk("stable.y", {22'd0, y1}, {22'd0, y0});
            chk("stable.v", {24'd0, v1}, {24'd0, v0});
            chk("stable.s", {30'd0, s1}, {30'd0, st0});
         end
      end
      flap = 1'b0;
      vsync = 1'b0;
      @(negedge dclk);
      if (stab) begin
         chk("tickcyc.y", {22'd0, y1}, {22'd0, y0});
         chk("tickcyc.v", {24'd0, v1}, {24'd0, v0});
      end
      @(negedge dclk);
      vsync = 1'b1;
      @(negedge dclk);
   endtask

   initial begin
      repeat (3) @(negedge dclk);
      chk1("reset", 215, 0, 0);
      chk2("reset", 215, 0, 0);
      clr = 1'b0;
      repeat (2) @(negedge dclk);

      // flap with vsync held high: no tick may happen
      flap = 1'b1;
      repeat (3) @(negedge dclk);
      flap = 1'b0;
      repeat (8) @(negedge dclk);
      chk1("no_tick", 215, 0, 0);

      // pending flap applied on the next tick
      frame(1'b0, 1'b0, 1'b0);
      chk1("launch", 207, -8, 1);
      frame(1'b0, 1'b0, 1'b1);
      chk1("gravity", 200, -7, 1);

      // collide with flap on the same tick
      frame(1'b1, 1'b1, 1'b0);
      chk1("collide", 200, -7, 2);
      for (int i = 0; i < 60; i++) begin
         frame(i == 10 || i == 59, 1'b1, 1'b0);
         if (i == 10) chk1("dead10", 200, -7, 2);
         if (i == 59) chk1("dead59", 200, -7, 2);
      end
      frame(1'b1, 1'b1, 1'b0);
      chk1("restart", 215, 0, 0);
      frame(1'b0, 1'b1, 1'b0);
      chk1("idle_coll", 215, 0, 0);

      // climb to the ceiling
      for (int k = 1; k <= 26; k++) begin
         frame(1'b1, 1'b0, 1'b0);
         if (k == 1) chk1("climb1", 207, -8, 1);
         if (k == 26) chk1("climb26", 7, -8, 1);
      end
      frame(1'b1, 1'b0, 1'b0);
      chk1("ceiling", 0, 0, 1);
      frame(1'b0, 1'b0, 1'b0);
      chk1("off_ceil", 1, 1, 1);

      // synchronous reset pulse, then flap edge coincident with tick
      clr = 1'b1;
      @(negedge dclk);
      clr = 1'b0;
      repeat (3) @(negedge dclk);
      chk1("reset2", 215, 0, 0);
      flap = 1'b1;
      @(negedge dclk);
      vsync = 1'b0;
      @(negedge dclk);
      @(negedge dclk);
      vsync = 1'b1;
      flap = 1'b0;
      chk1("coincide", 207, -8, 1);
      chk2("coincide", 215, 0, 1);
      repeat (3) @(negedge dclk);

      // asynchronous clear between clock edges
      #2 clr = 1'b1;
      #1;
      chk1("async_clr", 215, 0, 0);
      chk2("async_clr", 215, 0, 0);
      @(negedge dclk);
      clr = 1'b0;
      repeat (3) @(negedge dclk);

      // free fall with the zero-flap instance
      frame(1'b1, 1'b0, 1'b0);
      chk2("ff_start", 215, 0, 1);
      for (int k = 1; k <= 31; k++) begin
         frame(1'b0, 1'b0, 1'b0);
         if (k == 1) chk2("ff1", 216, 1, 1);
         if (k == 8) chk2("ff8", 251, 8, 1);
         if (k == 30) chk2("ff30", 427, 8, 1);
         if (k == 31) chk2("ff31", 430, 0, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
